// File: rtl/logic_pkg.sv
// Shared types for the round-robin logic-unit arbiter.
//   op_e    : 2-bit opcode selecting the bitwise function of the shared unit
//   OP_W    : opcode width per requester
//   state_e : occupancy of the single result register
package logic_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_rr_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker.
//   req     : pending requests, one bit per requester
//   ptr     : highest-priority index for this cycle
//   en      : allow a grant this cycle
//   gnt     : one-hot grant (all zero when en is low or nothing is pending)
//   gnt_idx : index of the first pending request at or after ptr, valid
//             whenever any request is pending, independent of en
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Walk ptr, ptr+1, ... with wrap; first pending one wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/logic_rr_arbiter.sv
// Round-robin arbiter in front of one shared BIT_LEN-wide logic unit
// (AND/OR/XOR/NAND built from NAND gates), with a single result register
// under valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready is the grant)
//   req_op/req_a/req_b    : per-requester opcode and operands, slice i
//   resp_valid/resp_ready : result register handshake
//   resp_id, resp_c       : owner index and result
//
// State table:
//   state    | meaning
//   ST_EMPTY | result register free, grants allowed
//   ST_FULL  | result register holds an undelivered result
module logic_rr_arbiter
  import logic_pkg::*;
#(
  parameter  int BIT_LEN = 1,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [OP_W*NUM_REQ-1:0]    req_op,
  input  logic [BIT_LEN*NUM_REQ-1:0] req_a,
  input  logic [BIT_LEN*NUM_REQ-1:0] req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [BIT_LEN-1:0]         resp_c
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               can_accept;
  logic               gnt_any;
  op_e                op_sel;
  logic [BIT_LEN-1:0] a_sel, b_sel;
  logic [BIT_LEN-1:0] nand_ab, and_v, or_v, xor_v, result;

  assign resp_valid = (state_q == ST_FULL);
  assign can_accept = !resp_valid || resp_ready;

  // Reset gates the picker so no grant leaks out while rst is high.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (can_accept && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  assign op_sel = op_e'(req_op[int'(gnt_idx)*OP_W +: OP_W]);
  assign a_sel  = req_a[int'(gnt_idx)*BIT_LEN +: BIT_LEN];
  assign b_sel  = req_b[int'(gnt_idx)*BIT_LEN +: BIT_LEN];

  // Shared unit, every function derived from two-input NANDs.
  assign nand_ab = ~(a_sel & b_sel);
  assign and_v   = ~nand_ab;
  assign or_v    = ~(~a_sel & ~b_sel);
  assign xor_v   = ~(~(a_sel & nand_ab) & ~(b_sel & nand_ab));

  always_comb begin
    result = and_v;
    case (op_sel)
      OP_AND:  result = and_v;
      OP_OR:   result = or_v;
      OP_XOR:  result = xor_v;
      OP_NAND: result = nand_ab;
      default: result = and_v;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (gnt_any) state_d = ST_FULL;
      ST_FULL:  if (resp_ready && !gnt_any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      resp_c   <= '0;
      resp_id  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        resp_c   <= result;
        resp_id  <= gnt_idx;
        rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_rr_arbiter.sv
module tb_logic_rr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]   req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic           resp_valid, resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_c;

  logic [1:0] req_valid2, req_ready2;
  logic [3:0] req_op2;
  logic [1:0] req_a2, req_b2;
  logic       resp_valid2, resp_ready2;
  logic       resp_id2;
  logic       resp_c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_rr_arbiter #(.BIT_LEN(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_c(resp_c)
  );

  logic_rr_arbiter #(.BIT_LEN(1), .NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op2), .req_a(req_a2), .req_b(req_b2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_id(resp_id2), .resp_c(resp_c2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] apply_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Behavioural model of the main instance: result register + priority pointer.
  bit           model_ok = 0;
  bit           m_valid;
  logic [W-1:0] m_c;
  int           m_id;
  int           m_ptr;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    g = -1;
    if (!rst && (!m_valid || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (model_ok) begin
      chk("model resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("model resp_c", 32'(resp_c), 32'(m_c));
      chk("model resp_id", 32'(resp_id), 32'(m_id));
      chk("model req_ready", 32'(req_ready), 32'(exp_rdy));
    end
    if (rst) begin
      m_valid = 0; m_c = '0; m_id = 0; m_ptr = 0;
      model_ok = 1;
    end else if (g >= 0) begin
      m_valid = 1;
      m_c = apply_op(int'(req_op[2*g +: 2]), req_a[W*g +: W], req_b[W*g +: W]);
      m_id = g;
      m_ptr = (g + 1) % N;
    end else if (resp_ready) begin
      m_valid = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_c [5];
  logic [3:0] tt [4];

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_c = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'hC0};
    // truth table indexed by {a,b}: AND, OR, XOR, NAND
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};

    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    req_valid2 = '0; req_op2 = '0; req_a2 = '0; req_b2 = '0; resp_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_c", 32'(resp_c), 0);
    chk("reset resp_id", 32'(resp_id), 0);
    chk("reset req_ready", 32'(req_ready), 0);

    // single request from requester 2
    nxt();
    req_valid = 4'b0100;
    req_op[5:4] = 2'b00; req_a[23:16] = 8'hF0; req_b[23:16] = 8'h3C;
    @(negedge clk);
    chk("single grant", 32'(req_ready), 32'h4);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("single resp_valid", 32'(resp_valid), 1);
    chk("single resp_id", 32'(resp_id), 2);
    chk("single resp_c", 32'(resp_c), 32'h30);

    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;

    // all requesters valid, full throughput
    req_op = {2'd3, 2'd2, 2'd1, 2'd0};
    req_a = {4{8'hF0}};
    req_b = {4{8'hCC}};
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr resp_c", 32'(resp_c), 32'(exp_c[k-1]));
        chk("rr resp_id", 32'(resp_id), 32'((k - 1) % 4));
      end
      nxt();
    end

    // backpressure for 3 cycles
    resp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall req_ready", 32'(req_ready), 0);
      chk("stall resp_valid", 32'(resp_valid), 1);
      chk("stall resp_c", 32'(resp_c), 32'hC0);
      chk("stall resp_id", 32'(resp_id), 0);
      nxt();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("unstall grant", 32'(req_ready), 32'h2);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("unstall resp_id", 32'(resp_id), 1);
    chk("unstall resp_c", 32'(resp_c), 32'hFC);

    // wrap and skip
    nxt();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("wrap grant3", 32'(req_ready), 32'h8);
    nxt();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("skip grant1", 32'(req_ready), 32'h2);
    chk("wrap resp_id", 32'(resp_id), 3);
    chk("wrap resp_c", 32'(resp_c), 32'h3F);
    nxt();
    @(negedge clk);
    chk("skip grant3", 32'(req_ready), 32'h8);
    chk("skip resp_id", 32'(resp_id), 1);

    // reset while holding a result with requests pending
    nxt();
    req_valid = 4'b0101;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("pre-reset stall", 32'(req_ready), 0);
    chk("pre-reset valid", 32'(resp_valid), 1);
    nxt(); rst = 1'b1;
    @(negedge clk);
    chk("in-reset req_ready", 32'(req_ready), 0);
    nxt();
    @(negedge clk);
    chk("reset drop valid", 32'(resp_valid), 0);
    chk("reset2 req_ready", 32'(req_ready), 0);
    nxt(); rst = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("post-reset priority", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("post-reset resp_id", 32'(resp_id), 0);
    chk("post-reset resp_c", 32'(resp_c), 32'hC0);

    // exhaustive 1-bit truth table on the 2-requester instance
    for (int o = 0; o < 4; o++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [3:0] row;
        logic [1:0] abv;
        nxt();
        abv = 2'(ab);
        req_valid2 = 2'b01;
        req_op2 = {2'b00, 2'(o)};
        req_a2 = {1'b0, abv[1]};
        req_b2 = {1'b0, abv[0]};
        @(negedge clk);
        chk("tt grant", 32'(req_ready2), 32'h1);
        nxt();
        req_valid2 = '0;
        @(negedge clk);
        row = tt[o];
        chk("tt resp_valid", 32'(resp_valid2), 1);
        chk("tt resp_id", 32'(resp_id2), 0);
        chk("tt resp_c", 32'(resp_c2), 32'(row[ab]));
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_rr_arbiter.md
# logic_rr_arbiter

Shares one BIT_LEN-wide bitwise logic unit (AND/OR/XOR/NAND, built from the NAND-based gate blocks) among NUM_REQ requesters. A round-robin arbiter picks one valid request per cycle, the shared unit evaluates it, and the result is held in a single output register with valid/ready backpressure. The block sits between the requesting sub-blocks and the logic datapath, so only one instance of the logic unit is needed per cluster.

## Interface
- BIT_LEN, 1, operand/result width
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  request pending, one bit per requester
- req_ready  output  NUM_REQ  grant, at most one bit high per cycle
- req_op  input  2*NUM_REQ  op per requester, slice i = [2*i+1:2*i]
- req_a  input  BIT_LEN*NUM_REQ  operand a per requester, slice i
- req_b  input  BIT_LEN*NUM_REQ  operand b per requester, slice i
- resp_valid  output  1  result register occupied
- resp_ready  input  1  consumer accepts result
- resp_id  output  ID_W  index of requester that owns resp_c
- resp_c  output  BIT_LEN  result

## Operation
- Op encoding: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND.
- Transfer on requester i: req_valid[i] && req_ready[i]. Transfer on output: resp_valid && resp_ready.
- can_accept = !resp_valid || resp_ready.
- Grant is combinational: if can_accept, req_ready = one-hot of the first set req_valid bit, searching from rr_ptr upward with wrap. Otherwise req_ready = 0.
- req_ready never depends on req_op/a/b, and is 0 when req_valid is 0.
- Accepting a request loads resp_c = op(a_i, b_i), resp_id = i, and resp_valid = 1. It also sets rr_ptr = (i+1) mod NUM_REQ.
- Output drained with no new grant: resp_valid -> 0. resp_c and resp_id hold their last value.
- Drain and accept in the same cycle: the register reloads with the new result and resp_valid stays 1. This gives full throughput of one op per cycle.
- Output stalled (resp_valid && !resp_ready): resp_* hold stable, all req_ready = 0, and rr_ptr holds.
- rr_ptr changes only on a grant.
- Two-state FSM on resp_valid:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on drain with no grant.
  - FULL -> FULL on a stall, or on drain plus grant.
- Requesters must hold req_valid and operands stable until granted. The arbiter does not check this.

## Timing
- Reset values: resp_valid 0, resp_c 0, resp_id 0, rr_ptr 0 (requester 0 has top priority after reset). req_ready is 0 during reset.
- Latency: a grant in cycle t gives resp_valid/resp_c valid from cycle t+1.
- Throughput: 1 result per cycle while resp_ready is held 1.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- Reset mid-operation: a held result is discarded and rr_ptr returns to 0. No grant is issued in a cycle where rst = 1.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure
- Package logic_pkg holds:
  - op_e enum: OP_AND, OP_OR, OP_XOR, OP_NAND
  - OP_W = 2
- Sub-module rr_pick (NUM_REQ): a combinational round-robin one-hot picker.
  - Inputs: req, ptr, en.
  - Outputs: gnt, gnt_idx.
- The shared logic unit is instantiated once, with operands selected by gnt_idx. The AND path uses the existing AND block.

## Test plan
- Reset, then single request: req_valid=4'b0100, op=AND, a=8'hF0, b=8'h3C -> req_ready=4'b0100, and the next cycle gives resp_valid=1, resp_id=2, resp_c=8'h30.
- All four valid every cycle, resp_ready=1, ops cycled AND/OR/XOR/NAND -> grants go 0,1,2,3,0 on consecutive cycles, and each resp_c is correct per op.
- Backpressure: resp_ready=0 for 3 cycles with requests pending -> resp_* stable, req_ready=0, rr_ptr unchanged. Raising resp_ready then gives a grant in the same cycle, with no lost or duplicated result.
- Wrap and skip: after a grant to 3, req_valid=4'b1010 -> grant 1 next, then 3.
- Reset asserted while resp_valid=1 and requests are pending -> the next cycle has resp_valid=0 and no req_ready. After release, requester 0 wins over 2.
- BIT_LEN=1 and NUM_REQ=2: exhaustive a/b/op check -> resp_c matches the truth table for all 16 combinations.
